// File: rtl/ibex_instr_bus_xbar_if.sv
// Instruction-bus bundle between the fetch port, the router and N memories.
// master: environment view (core + memories); slave: router view.
interface ibex_instr_bus_xbar_if #(
  parameter int N_SLAVES = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
);
  logic                   m_req;
  logic [AW-1:0]          m_addr;
  logic                   m_gnt;
  logic                   m_rvalid;
  logic                   m_err;
  logic [DW-1:0]          m_rdata;

  logic [N_SLAVES-1:0]    s_req;
  logic [AW-1:0]          s_addr;
  logic [N_SLAVES-1:0]    s_gnt;
  logic [N_SLAVES-1:0]    s_rvalid;
  logic [N_SLAVES-1:0]    s_err;
  logic [N_SLAVES*DW-1:0] s_rdata;

  modport master (
    output m_req,
    output m_addr,
    input  m_gnt,
    input  m_rvalid,
    input  m_err,
    input  m_rdata,
    input  s_req,
    input  s_addr,
    output s_gnt,
    output s_rvalid,
    output s_err,
    output s_rdata
  );

  modport slave (
    input  m_req,
    input  m_addr,
    output m_gnt,
    output m_rvalid,
    output m_err,
    output m_rdata,
    output s_req,
    output s_addr,
    input  s_gnt,
    input  s_rvalid,
    input  s_err,
    input  s_rdata
  );
endinterface

// File: rtl/ibex_instr_bus_xbar.sv
// Instruction-bus router: address decode, in-order response tracking.
// Ports: clk, rst_n (sync, active-low), bus (slave modport), unexpected_rvalid.
module ibex_instr_bus_xbar #(
  parameter int N_SLAVES        = 2,
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = '0
) (
  input  logic clk,
  input  logic rst_n,
  ibex_instr_bus_xbar_if.slave bus,
  output logic unexpected_rvalid
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic          err;
    logic [IW-1:0] idx;
  } ent_t;

  ent_t          r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_unexp;

  logic                w_hit;
  logic [IW-1:0]       w_idx;
  logic                w_full;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_live;
  ent_t                w_head;
  logic [N_SLAVES-1:0] w_exp;
  logic                w_stray;
  logic                w_rvalid;
  logic                w_err;
  logic [DW-1:0]       w_rdata;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  // Scan downwards so the lowest matching index is the one left.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((bus.m_addr & SLAVE_MASK[i*AW +: AW]) ==
          SLAVE_BASE[i*AW +: AW]) begin
        w_hit = 1'b1;
        w_idx = IW'(i);
      end
    end
  end

  // A full FIFO blocks requests even when a pop is happening this cycle.
  assign w_full   = (r_count == CW'(MAX_OUTSTANDING));
  assign w_accept = bus.m_req & rst_n & ~w_full;

  // Unmapped requests are granted locally and answered later with an error.
  always_comb begin
    bus.s_req = '0;
    w_push    = 1'b0;
    if (w_accept) begin
      if (w_hit) begin
        bus.s_req[w_idx] = 1'b1;
        w_push           = bus.s_gnt[w_idx];
      end else begin
        w_push = 1'b1;
      end
    end
  end

  assign bus.m_gnt  = w_push;
  assign bus.s_addr = bus.m_addr;

  assign w_live = rst_n & (r_count != '0);
  assign w_head = r_fifo[r_rptr];

  always_comb begin
    w_rvalid = 1'b0;
    w_err    = 1'b0;
    w_rdata  = '0;
    w_exp    = '0;
    unique case (1'b1)
      (w_live & w_head.err): begin
        w_rvalid = 1'b1;
        w_err    = 1'b1;
      end
      (w_live & ~w_head.err): begin
        w_rvalid          = bus.s_rvalid[w_head.idx];
        w_err             = bus.s_err[w_head.idx];
        w_rdata           = bus.s_rdata[w_head.idx*DW +: DW];
        w_exp[w_head.idx] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.m_rvalid = w_rvalid;
  assign bus.m_err    = w_err;
  assign bus.m_rdata  = w_rdata;

  assign w_pop   = w_rvalid;
  // Any rvalid from a slave that is not the mapped head is dropped.
  assign w_stray = |(bus.s_rvalid & ~w_exp);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= '{err: ~w_hit, idx: w_idx};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_unexp <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= f_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= f_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_stray) begin
        r_unexp <= 1'b1;
      end
    end
  end

  assign unexpected_rvalid = r_unexp;

endmodule

// File: tb/tb_ibex_instr_bus_xbar.sv
// Bench for ibex_instr_bus_xbar: vector table, corner sequences, random.
// Random phase checks against a queue model of the in-flight fetches.
module tb_ibex_instr_bus_xbar;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam logic [N*AW-1:0] BASE = {32'h0001_0000, 32'h0000_0000};
  localparam logic [N*AW-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic unexp;

  int checks = 0;
  int errors = 0;

  ibex_instr_bus_xbar_if #(.N_SLAVES(N), .AW(AW), .DW(DW)) bus();

  ibex_instr_bus_xbar #(
    .N_SLAVES(N),
    .AW(AW),
    .DW(DW),
    .MAX_OUTSTANDING(MO),
    .SLAVE_BASE(BASE),
    .SLAVE_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .unexpected_rvalid(unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        serr;
    logic [1:0]  sreq;
    logic        merr;
    logic [31:0] mdata;
  } vec_t;

  vec_t tbl [7];

  int          q [$];
  logic [31:0] a;
  int          tgt;
  int          sel;
  int          h;
  logic [1:0]  g;
  logic [1:0]  srv;
  logic [1:0]  ser;
  logic [1:0]  exp_sreq;
  logic [63:0] rd;
  bit          req;
  bit          rv;
  bit          se;
  bit          exp_acc;
  bit          exp_gnt;
  bit          exp_rv;
  bit          exp_err;
  logic [31:0] exp_data;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic idle();
    bus.m_req    = 1'b0;
    bus.m_addr   = '0;
    bus.s_gnt    = '0;
    bus.s_rvalid = '0;
    bus.s_err    = '0;
    bus.s_rdata  = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 32'h0000_0013, 1'b0, 2'b01, 1'b0, 32'h0000_0013};
    tbl[1] = '{32'h0001_0040, 32'hDEAD_BEEF, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{32'h2000_0000, 32'h1111_1111, 1'b0, 2'b00, 1'b1, 32'h0};
    tbl[3] = '{32'h0000_FFFC, 32'h0000_A5A5, 1'b1, 2'b01, 1'b1, 32'h0000_A5A5};
    tbl[4] = '{32'h0001_FFFC, 32'h0000_1234, 1'b0, 2'b10, 1'b0, 32'h0000_1234};
    tbl[5] = '{32'hFFFF_FFFF, 32'h2222_2222, 1'b0, 2'b00, 1'b1, 32'h0};
    tbl[6] = '{32'h0002_0000, 32'h3333_3333, 1'b0, 2'b00, 1'b1, 32'h0};

    idle();
    rst_n      = 1'b0;
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0000_0100;
    bus.s_gnt  = 2'b11;
    @(negedge clk);
    #1;
    chk("rst_sreq", 32'(bus.s_req), 32'h0);
    chk("rst_gnt", 32'(bus.m_gnt), 32'h0);
    chk("rst_rvalid", 32'(bus.m_rvalid), 32'h0);
    nxt();
    #1;
    chk("rst_unexp", 32'(unexp), 32'h0);
    idle();
    rst_n = 1'b1;
    nxt();

    foreach (tbl[i]) begin
      bus.m_req  = 1'b1;
      bus.m_addr = tbl[i].addr;
      bus.s_gnt  = 2'b11;
      #1;
      chk($sformatf("vec%0d_sreq", i), 32'(bus.s_req), 32'(tbl[i].sreq));
      chk($sformatf("vec%0d_gnt", i), 32'(bus.m_gnt), 32'h1);
      chk($sformatf("vec%0d_rv_early", i), 32'(bus.m_rvalid), 32'h0);
      nxt();
      bus.m_req = 1'b0;
      bus.s_gnt = 2'b00;
      if (tbl[i].sreq != 2'b00) begin
        bus.s_rvalid = tbl[i].sreq;
        bus.s_err    = tbl[i].serr ? tbl[i].sreq : 2'b00;
        bus.s_rdata  = {tbl[i].rdata, tbl[i].rdata};
      end
      #1;
      chk($sformatf("vec%0d_rvalid", i), 32'(bus.m_rvalid), 32'h1);
      chk($sformatf("vec%0d_err", i), 32'(bus.m_err), 32'(tbl[i].merr));
      chk($sformatf("vec%0d_rdata", i), bus.m_rdata, tbl[i].mdata);
      nxt();
      idle();
      #1;
      chk($sformatf("vec%0d_rv_after", i), 32'(bus.m_rvalid), 32'h0);
      nxt();
    end

    // Cross-slave ordering: slave 0 slow, slave 1 held back behind it.
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0000_0000;
    bus.s_gnt  = 2'b11;
    #1;
    chk("ord_gnt0", 32'(bus.m_gnt), 32'h1);
    nxt();
    bus.m_addr = 32'h0001_0000;
    #1;
    chk("ord_sreq1", 32'(bus.s_req), 32'h2);
    chk("ord_gnt1", 32'(bus.m_gnt), 32'h1);
    nxt();
    idle();
    #1;
    chk("ord_wait", 32'(bus.m_rvalid), 32'h0);
    nxt();
    bus.s_rvalid = 2'b01;
    bus.s_rdata  = {32'h0000_0222, 32'h0000_0111};
    #1;
    chk("ord_rv0", 32'(bus.m_rvalid), 32'h1);
    chk("ord_data0", bus.m_rdata, 32'h0000_0111);
    nxt();
    bus.s_rvalid = 2'b10;
    #1;
    chk("ord_rv1", 32'(bus.m_rvalid), 32'h1);
    chk("ord_data1", bus.m_rdata, 32'h0000_0222);
    nxt();
    idle();
    #1;
    chk("ord_empty", 32'(bus.m_rvalid), 32'h0);
    chk("ord_unexp", 32'(unexp), 32'h0);
    nxt();

    // Full stall: two fetches in flight, third waits for a pop.
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0000_0000;
    bus.s_gnt  = 2'b11;
    #1;
    chk("full_gnt0", 32'(bus.m_gnt), 32'h1);
    nxt();
    bus.m_addr = 32'h0001_0000;
    #1;
    chk("full_gnt1", 32'(bus.m_gnt), 32'h1);
    nxt();
    bus.m_addr = 32'h0000_0100;
    #1;
    chk("full_gnt_stall", 32'(bus.m_gnt), 32'h0);
    chk("full_sreq_stall", 32'(bus.s_req), 32'h0);
    nxt();
    bus.s_rvalid = 2'b01;
    bus.s_rdata  = {32'h0, 32'h0000_0055};
    #1;
    chk("full_pop_rv", 32'(bus.m_rvalid), 32'h1);
    chk("full_pop_gnt", 32'(bus.m_gnt), 32'h0);
    chk("full_pop_sreq", 32'(bus.s_req), 32'h0);
    nxt();
    bus.s_rvalid = 2'b00;
    #1;
    chk("full_resume_gnt", 32'(bus.m_gnt), 32'h1);
    chk("full_resume_sreq", 32'(bus.s_req), 32'h1);
    nxt();
    bus.m_req    = 1'b0;
    bus.s_rvalid = 2'b10;
    bus.s_rdata  = {32'h0000_0066, 32'h0000_0077};
    #1;
    chk("full_drain1_rv", 32'(bus.m_rvalid), 32'h1);
    chk("full_drain1_data", bus.m_rdata, 32'h0000_0066);
    nxt();
    bus.s_rvalid = 2'b01;
    #1;
    chk("full_drain0_rv", 32'(bus.m_rvalid), 32'h1);
    chk("full_drain0_data", bus.m_rdata, 32'h0000_0077);
    nxt();
    idle();
    #1;
    chk("full_empty", 32'(bus.m_rvalid), 32'h0);
    chk("full_unexp", 32'(unexp), 32'h0);
    nxt();

    // Stray response with an empty FIFO.
    bus.s_rvalid = 2'b10;
    bus.s_rdata  = {32'hCAFE_0000, 32'h0};
    #1;
    chk("unexp_rv", 32'(bus.m_rvalid), 32'h0);
    chk("unexp_data", bus.m_rdata, 32'h0);
    chk("unexp_pre", 32'(unexp), 32'h0);
    nxt();
    idle();
    #1;
    chk("unexp_set", 32'(unexp), 32'h1);
    nxt();
    nxt();
    #1;
    chk("unexp_held", 32'(unexp), 32'h1);
    nxt();

    // Reset with one fetch outstanding.
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0000_0100;
    bus.s_gnt  = 2'b11;
    #1;
    chk("rmid_gnt", 32'(bus.m_gnt), 32'h1);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("rmid_gnt_rst", 32'(bus.m_gnt), 32'h0);
    chk("rmid_sreq_rst", 32'(bus.s_req), 32'h0);
    chk("rmid_rv_rst", 32'(bus.m_rvalid), 32'h0);
    nxt();
    rst_n = 1'b1;
    idle();
    #1;
    chk("rmid_rv_after", 32'(bus.m_rvalid), 32'h0);
    chk("rmid_unexp", 32'(unexp), 32'h0);
    nxt();
    bus.m_req  = 1'b1;
    bus.m_addr = 32'h0001_0008;
    bus.s_gnt  = 2'b11;
    #1;
    chk("rmid_new_gnt", 32'(bus.m_gnt), 32'h1);
    chk("rmid_new_sreq", 32'(bus.s_req), 32'h2);
    nxt();
    idle();
    bus.s_rvalid = 2'b10;
    bus.s_rdata  = {32'h0000_0099, 32'h0};
    #1;
    chk("rmid_new_rv", 32'(bus.m_rvalid), 32'h1);
    chk("rmid_new_data", bus.m_rdata, 32'h0000_0099);
    chk("rmid_new_err", 32'(bus.m_err), 32'h0);
    nxt();
    idle();
    #1;
    chk("rmid_new_empty", 32'(bus.m_rvalid), 32'h0);
    nxt();

    // Random traffic against an in-order queue of outstanding targets.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 2);
      a   = $urandom;
      if (sel == 0)      a[31:16] = 16'h0000;
      else if (sel == 1) a[31:16] = 16'h0001;
      else               a[31]    = 1'b1;
      tgt = (a[31:16] == 16'h0000) ? 0 :
            (a[31:16] == 16'h0001) ? 1 : -1;
      g   = 2'($urandom);
      rd  = {$urandom, $urandom};

      exp_acc  = req && (q.size() < MO);
      exp_sreq = (exp_acc && tgt >= 0) ? (2'b01 << tgt) : 2'b00;
      exp_gnt  = exp_acc && (tgt < 0 || g[tgt]);

      srv      = 2'b00;
      ser      = 2'b00;
      exp_rv   = 1'b0;
      exp_err  = 1'b0;
      exp_data = 32'h0;
      if (q.size() > 0) begin
        h = q[0];
        if (h < 0) begin
          exp_rv  = 1'b1;
          exp_err = 1'b1;
        end else begin
          rv = ($urandom_range(0, 2) != 0);
          se = ($urandom_range(0, 3) == 0);
          if (rv) begin
            srv[h] = 1'b1;
            ser[h] = se;
          end
          exp_rv   = rv;
          exp_err  = rv && se;
          exp_data = rd[h*32 +: 32];
        end
      end

      bus.m_req    = req;
      bus.m_addr   = a;
      bus.s_gnt    = g;
      bus.s_rvalid = srv;
      bus.s_err    = ser;
      bus.s_rdata  = rd;
      #1;
      chk("rnd_sreq", 32'(bus.s_req), 32'(exp_sreq));
      chk("rnd_gnt", 32'(bus.m_gnt), 32'(exp_gnt));
      chk("rnd_saddr", bus.s_addr, a);
      chk("rnd_rvalid", 32'(bus.m_rvalid), 32'(exp_rv));
      chk("rnd_err", 32'(bus.m_err), 32'(exp_err));
      chk("rnd_rdata", bus.m_rdata, exp_data);
      chk("rnd_unexp", 32'(unexp), 32'h0);
      @(posedge clk);
      if (exp_rv) void'(q.pop_front());
      if (exp_gnt) q.push_back(tgt);
      @(negedge clk);
    end

    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
